// File: rtl/simon_sequencer_if.sv
// Simon sequencer bus: game control, player buttons and display outputs.
// Handshake: playerPressed is a single-cycle qualifier for playerNum. The
// sequencer samples playerNum only in a cycle where playerPressed is high.
// It never back-pressures, so there is no ready, and a press that arrives
// while the sequencer is not listening is dropped rather than queued.
// start and tick are plain single-cycle pulses with the same no-ready rule.
// fsm_state mirrors the sequencer's state register for observation.
interface simon_sequencer_if;
   logic       start;
   logic       tick;
   logic [1:0] playerNum;
   logic       playerPressed;
   logic       simonTurn;
   logic [1:0] simonNum;
   logic       simonPressed;
   logic [5:0] level;
   logic       gameOver;
   logic       win;
   logic [2:0] fsm_state;

   modport master (
      output start, tick, playerNum, playerPressed,
      input  simonTurn, simonNum, simonPressed, level, gameOver, win, fsm_state
   );

   modport slave (
      input  start, tick, playerNum, playerPressed,
      output simonTurn, simonNum, simonPressed, level, gameOver, win, fsm_state
   );
endinterface

// File: rtl/simon_sequencer.sv
// Simon game sequencer: grows a random 2-bit button sequence one step per
// level, plays it back with lit/dark timing and checks the player's echo.
module simon_sequencer #(
   parameter int MAX_LEN       = 16,
   parameter int ON_TICKS      = 4,
   parameter int OFF_TICKS     = 2,
   parameter int TIMEOUT_TICKS = 20
) (
   input  logic               clk,
   input  logic               rst,
   simon_sequencer_if.slave   bus
);
   localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int T1   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int TMAX = (T1 > TIMEOUT_TICKS) ? T1 : TIMEOUT_TICKS;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADD      = 3'd1,
      SHOW_ON  = 3'd2,
      SHOW_OFF = 3'd3,
      LISTEN   = 3'd4,
      OVER     = 3'd5,
      WIN      = 3'd6
   } state_t;

   state_t        state, state_n;
   logic [15:0]   lfsr;
   logic          lfsr_fb;
   // Depth rounded up to a power of two so idx/len slices index it exactly.
   logic [1:0]    mem [2**AW];
   logic [5:0]    len, len_n;
   logic [AW-1:0] idx, idx_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic          mem_we;
   logic          idx_last;
   logic [1:0]    cur_sym;
   logic [1:0]    show_sym;

   logic          turn_n, lit_n, over_n, win_n;
   logic [1:0]    num_n;
   logic          turn_q, lit_q, over_q, win_q;
   logic [1:0]    num_q;
   logic [5:0]    level_q;

   assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign idx_last = (6'(idx) == len - 6'd1);
   assign cur_sym  = mem[idx];

   // State, counters, LFSR and registered outputs; rst wins over every input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         len     <= '0;
         idx     <= '0;
         tcnt    <= '0;
         lfsr    <= 16'hACE1;
         turn_q  <= 1'b0;
         lit_q   <= 1'b0;
         num_q   <= 2'd0;
         level_q <= 6'd0;
         over_q  <= 1'b0;
         win_q   <= 1'b0;
      end else begin
         state   <= state_n;
         len     <= len_n;
         idx     <= idx_n;
         tcnt    <= tcnt_n;
         lfsr    <= {lfsr_fb, lfsr[15:1]};
         turn_q  <= turn_n;
         lit_q   <= lit_n;
         num_q   <= num_n;
         level_q <= len_n;
         over_q  <= over_n;
         win_q   <= win_n;
      end
   end

   // Sequence memory: one new symbol appended per ADD, never cleared.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[len[AW-1:0]] <= lfsr[1:0];
      end
   end

   // Next-state and counter updates for the game flow.
   always_comb begin
      state_n = state;
      len_n   = len;
      idx_n   = idx;
      tcnt_n  = tcnt;
      mem_we  = 1'b0;
      case (state)
         IDLE, OVER, WIN: begin
            if (bus.start) begin
               len_n   = 6'd0;
               state_n = ADD;
            end
         end
         ADD: begin
            mem_we  = 1'b1;
            len_n   = len + 6'd1;
            idx_n   = '0;
            tcnt_n  = '0;
            state_n = SHOW_ON;
         end
         SHOW_ON: begin
            if (bus.tick) begin
               if (tcnt == TW'(ON_TICKS - 1)) begin
                  tcnt_n  = '0;
                  state_n = SHOW_OFF;
               end else begin
                  tcnt_n = tcnt + TW'(1);
               end
            end
         end
         SHOW_OFF: begin
            if (bus.tick) begin
               if (tcnt == TW'(OFF_TICKS - 1)) begin
                  tcnt_n = '0;
                  if (idx_last) begin
                     idx_n   = '0;
                     state_n = LISTEN;
                  end else begin
                     idx_n   = idx + AW'(1);
                     state_n = SHOW_ON;
                  end
               end else begin
                  tcnt_n = tcnt + TW'(1);
               end
            end
         end
         LISTEN: begin
            // A press beats a timeout-completing tick in the same cycle.
            if (bus.playerPressed) begin
               if (bus.playerNum != cur_sym) begin
                  state_n = OVER;
               end else if (idx_last) begin
                  state_n = (len == 6'(MAX_LEN)) ? WIN : ADD;
               end else begin
                  idx_n  = idx + AW'(1);
                  tcnt_n = '0;
               end
            end else if (bus.tick) begin
               if (tcnt == TW'(TIMEOUT_TICKS - 1)) begin
                  state_n = OVER;
               end else begin
                  tcnt_n = tcnt + TW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Output values for the coming cycle, decoded from the next state.
   always_comb begin
      // The first symbol shown is the one being written this very cycle.
      show_sym = (mem_we && (len[AW-1:0] == idx_n)) ? lfsr[1:0] : mem[idx_n];
      turn_n   = (state_n == SHOW_ON) || (state_n == SHOW_OFF);
      lit_n    = (state_n == SHOW_ON);
      num_n    = turn_n ? show_sym : 2'd0;
      over_n   = (state_n == OVER);
      win_n    = (state_n == WIN);
   end

   assign bus.simonTurn    = turn_q;
   assign bus.simonPressed = lit_q;
   assign bus.simonNum     = num_q;
   assign bus.level        = level_q;
   assign bus.gameOver     = over_q;
   assign bus.win          = win_q;
   assign bus.fsm_state    = state;
endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 Parameter MAX_LEN, 16, maximum sequence length (level at which the game is won), 2..32.
REQ-002 Parameter ON_TICKS, 4, tick pulses a playback step is lit.
REQ-003 Parameter OFF_TICKS, 2, tick pulses of dark gap after each playback step.
REQ-004 Parameter TIMEOUT_TICKS, 20, tick pulses allowed between player presses.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle pulse that begins a new game.
REQ-008 tick  input  1  single-cycle timebase pulse, arbitrary spacing of at least 1 clk.
REQ-009 playerNum  input  2  button index of the player press.
REQ-010 playerPressed  input  1  single-cycle pulse qualifying playerNum.
REQ-011 simonTurn  output  1  high while the sequence is being played back.
REQ-012 simonNum  output  2  button index being shown; 0 when not showing.
REQ-013 simonPressed  output  1  high while the shown button is lit.
REQ-014 level  output  6  current sequence length.
REQ-015 gameOver  output  1  high in OVER state.
REQ-016 win  output  1  high in WIN state.

Function
REQ-017 The block SHALL hold a 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every clk cycle in every state.
REQ-018 The block SHALL hold a MAX_LEN x 2-bit sequence memory, a length counter len, an index idx and a tick counter tcnt.
REQ-019 States SHALL be IDLE, ADD, SHOW_ON, SHOW_OFF, LISTEN, OVER, WIN; all outputs registered.
REQ-020 IDLE/OVER/WIN: start -> len<=0, then ADD next cycle; start ignored in all other states.
REQ-021 ADD (1 cycle): mem[len]<=lfsr[1:0], len<=len+1, idx<=0, tcnt<=0 -> SHOW_ON.
REQ-022 SHOW_ON: simonTurn=1, simonPressed=1, simonNum=mem[idx]; tcnt counts tick; at ON_TICKS ticks -> SHOW_OFF, tcnt<=0.
REQ-023 SHOW_OFF: simonTurn=1, simonPressed=0, simonNum=mem[idx]; at OFF_TICKS ticks: if idx==len-1 -> LISTEN with idx<=0, tcnt<=0, else idx<=idx+1 -> SHOW_ON.
REQ-024 playerPressed SHALL be ignored outside LISTEN (no queuing).
REQ-025 LISTEN: simonTurn=0; on playerPressed compare playerNum to mem[idx]: mismatch -> OVER; match with idx<len-1 -> idx+1, tcnt<=0, stay.
REQ-026 LISTEN, match on idx==len-1: len==MAX_LEN -> WIN, else -> ADD.
REQ-027 LISTEN: tcnt counts tick; reaching TIMEOUT_TICKS with no press -> OVER.
REQ-028 Press and timeout-completing tick in the same cycle: the press SHALL be evaluated, the timeout discarded.
REQ-029 level SHALL equal len; len never exceeds MAX_LEN; idx never exceeds len-1.
REQ-030 OVER/WIN SHALL hold level at the reached value until start or rst.

Reset
REQ-031 rst SHALL, in any state including mid-playback, force IDLE next edge: len=0, idx=0, tcnt=0, lfsr=16'hACE1, all outputs 0.
REQ-032 rst SHALL take priority over start, tick and playerPressed in the same cycle.
REQ-033 Sequence memory contents need not be cleared by rst.

Verification
REQ-034 rst, start, tick every 4 clk -> level=1, simonPressed high 4 ticks, low 2 ticks, then simonTurn=0.
REQ-035 Echo each shown simonNum during LISTEN through level 3 -> each level replays prior prefix unchanged, level increments 1,2,3,4.
REQ-036 At level 2 press wrong button on idx 1 -> gameOver=1 next cycle, level=2 held; start -> gameOver=0, level=1.
REQ-037 LISTEN with no press for 20 ticks -> gameOver=1; press coincident with 20th tick and correct -> no gameOver.
REQ-038 MAX_LEN=2, echo correctly twice -> win=1, level=2; presses during SHOW ignored.
REQ-039 rst asserted mid SHOW_ON with start same cycle -> IDLE, all outputs 0, start ignored.
